zf_symbol_slicer: RTL and testbench

- Downstream stage of the ZF preprocess block in the 2x2 MIMO ZF detector.
- Consumes its 128-bit equalized vector: 8 signed 16-bit real-valued elements, i.e. the real and imaginary parts of two 16-QAM streams.
- Slices one element per cycle to a 4-PAM level, Gray-demaps each element to 2 bits, and counts out-of-range elements.
- Uses the same enable / accept / ready handshake as the rest of the detector chain.

---
 rtl/zf_pkg.sv | 21 ++
 rtl/pam4_slicer.sv | 32 +++
 rtl/zf_symbol_slicer.sv | 94 +++++++++
 tb/tb_zf_symbol_slicer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/zf_pkg.sv
// Shared types and constants for the ZF detector chain: FSM state encoding,
// 4-PAM Gray codes and default element geometry.
package zf_pkg;

  localparam int W_DEFAULT         = 16;
  localparam int N_ELEM_DEFAULT    = 8;
  localparam int FRAC_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLICE = 2'd1,
    READY = 2'd2
  } state_t;

  // Gray mapping of the four PAM levels -3, -1, +1, +3
  localparam logic [1:0] G_M3 = 2'b00;
  localparam logic [1:0] G_M1 = 2'b01;
  localparam logic [1:0] G_P1 = 2'b11;
  localparam logic [1:0] G_P3 = 2'b10;

endpackage

// File: rtl/pam4_slicer.sv
// Combinational 4-PAM hard decision on one signed fixed-point element,
// producing the Gray code of the nearest level and an out-of-range flag.
module pam4_slicer
  import zf_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic signed [W-1:0] x,
  output logic        [1:0]   gray,
  output logic                ovf
);

  // Two guard bits keep +/-4S representable for any element width.
  localparam logic signed [W+1:0] TWO_S  = (W+2)'(1) << (FRAC_BITS + 1);
  localparam logic signed [W+1:0] FOUR_S = (W+2)'(1) << (FRAC_BITS + 2);

  logic signed [W+1:0] xe;
  assign xe = {{2{x[W-1]}}, x};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and a latch is never inferred.
  always_comb begin
    gray = G_M3;
    ovf  = 1'b0;
    if (xe >= TWO_S)       gray = G_P3;
    else if (!xe[W+1])     gray = G_P1;
    else if (xe >= -TWO_S) gray = G_M1;
    ovf = (xe >= FOUR_S) || (xe < -FOUR_S);
  end

endmodule

// File: rtl/zf_symbol_slicer.sv
// Slices the equalized ZF vector one element per cycle into Gray-coded 4-PAM
// bits and counts out-of-range elements, behind the enable/accept/ready handshake.
module zf_symbol_slicer
  import zf_pkg::*;
#(
  parameter int W         = W_DEFAULT,
  parameter int N_ELEM    = N_ELEM_DEFAULT,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            accept_in,
  output logic                            accept_out,
  output logic                            ready_out,
  input  logic [W*N_ELEM-1:0]             Q_processed,
  output logic [2*N_ELEM-1:0]             bits_out,
  output logic [$clog2(N_ELEM+1)-1:0]     ovf_count
);

  localparam int IDX_W = $clog2(N_ELEM);
  localparam int CNT_W = $clog2(N_ELEM + 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [W*N_ELEM-1:0] data_q;

  logic signed [W-1:0] elem;
  logic [1:0]          gray;
  logic                ovf;

  // Element 0 sits in the most significant slot of the vector.
  assign elem = data_q[W*(N_ELEM-1-int'(idx)) +: W];

  pam4_slicer #(
    .W         (W),
    .FRAC_BITS (FRAC_BITS)
  ) u_slicer (
    .x    (elem),
    .gray (gray),
    .ovf  (ovf)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the data register is a plain register, so it is reset too.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      data_q     <= '0;
      bits_out   <= '0;
      ovf_count  <= '0;
      accept_out <= 1'b1;
      ready_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            data_q     <= Q_processed;
            bits_out   <= '0;
            ovf_count  <= '0;
            idx        <= '0;
            state      <= SLICE;
            accept_out <= 1'b0;
          end
        end
        SLICE: begin
          bits_out[2*(N_ELEM-1-int'(idx)) +: 2] <= gray;
          ovf_count <= ovf_count + CNT_W'(ovf);
          if (idx == IDX_W'(N_ELEM - 1)) begin
            state     <= READY;
            ready_out <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        READY: begin
          // A simultaneous enable is not taken; capture happens from IDLE only.
          if (accept_in) begin
            state      <= IDLE;
            ready_out  <= 1'b0;
            accept_out <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          accept_out <= 1'b1;
          ready_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zf_symbol_slicer.sv
// Directed, table-driven bench for zf_symbol_slicer with hand-computed vectors
// plus sequences for READY hold, handshake overlap and mid-run reset.
module tb_zf_symbol_slicer;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         accept_in;
  logic         accept_out;
  logic         ready_out;
  logic [127:0] Q_processed;
  logic [15:0]  bits_out;
  logic [3:0]   ovf_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zf_symbol_slicer dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .accept_in   (accept_in),
    .accept_out  (accept_out),
    .ready_out   (ready_out),
    .Q_processed (Q_processed),
    .bits_out    (bits_out),
    .ovf_count   (ovf_count)
  );

  typedef struct {
    string        name;
    logic [127:0] q;
    logic [15:0]  bits;
    logic [3:0]   ovf;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [127:0] pack8(input logic [15:0] e0, e1, e2, e3,
                                                            e4, e5, e6, e7);
    return {e0, e1, e2, e3, e4, e5, e6, e7};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic start(input logic [127:0] q);
    Q_processed = q;
    enable      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
  endtask

  // Counts capture edge as 1; optionally pokes enable and new data mid-SLICE.
  task automatic wait_ready(input bit poke, output int edges);
    edges = 1;
    while (ready_out !== 1'b1 && edges < 20) begin
      if (poke && edges == 3) begin
        enable      = 1'b1;
        Q_processed = {8{16'h7FFF}};
      end else begin
        enable = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    enable = 1'b0;
  endtask

  task automatic do_accept(input string tag);
    accept_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    accept_in = 1'b0;
    check({tag, "_accept_out"}, 32'(accept_out), 32'd1);
    check({tag, "_ready_low"}, 32'(ready_out), 32'd0);
  endtask

  logic [127:0] test_vec;
  int           edges;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_vec = pack8(16'h0258, 16'h0064, 16'hFF9C, 16'hFDA8,
                     16'h0200, 16'hFE00, 16'h0400, 16'hFBFF);
    vecs[0] = '{"zeros",    '0,                 16'hFFFF, 4'd0};
    vecs[1] = '{"mixed",    test_vec,           16'hB498, 4'd2};
    vecs[2] = '{"bounds",   pack8(16'h01FF, 16'hFE01, 16'hFDFF, 16'h03FF,
                                  16'hFC00, 16'h0001, 16'hFFFF, 16'h0000),
                                                16'hD237, 4'd0};
    vecs[3] = '{"all_max",  {8{16'h7FFF}},      16'hAAAA, 4'd8};
    vecs[4] = '{"zeros_b2b", '0,                16'hFFFF, 4'd0};
    vecs[5] = '{"all_min",  {8{16'h8000}},      16'h0000, 4'd8};

    reset = 1'b1; enable = 1'b0; accept_in = 1'b0; Q_processed = '0;
    repeat (2) @(negedge clk);
    check("rst_accept_out", 32'(accept_out), 32'd1);
    check("rst_ready_out",  32'(ready_out),  32'd0);
    check("rst_bits",       32'(bits_out),   32'd0);
    check("rst_ovf",        32'(ovf_count),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      start(vecs[i].q);
      check({vecs[i].name, "_slice_busy"}, 32'(accept_out), 32'd0);
      wait_ready(1'b0, edges);
      check({vecs[i].name, "_latency"}, 32'(edges), 32'd9);
      check({vecs[i].name, "_bits"}, 32'(bits_out), 32'(vecs[i].bits));
      check({vecs[i].name, "_ovf"}, 32'(ovf_count), 32'(vecs[i].ovf));
      do_accept(vecs[i].name);
      check({vecs[i].name, "_idle_hold"}, 32'(bits_out), 32'(vecs[i].bits));
    end

    // READY hold with changing input, after an enable poke during SLICE
    start(test_vec);
    wait_ready(1'b1, edges);
    check("poke_latency", 32'(edges), 32'd9);
    for (int c = 0; c < 5; c++) begin
      Q_processed = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      check("hold_ready", 32'(ready_out), 32'd1);
      check("hold_bits",  32'(bits_out),  32'h0000B498);
      check("hold_ovf",   32'(ovf_count), 32'd2);
    end

    // enable together with accept_in: accepted, not captured
    Q_processed = '0;
    enable      = 1'b1;
    accept_in   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    accept_in = 1'b0;
    check("overlap_idle",      32'(accept_out), 32'd1);
    check("overlap_ready_low", 32'(ready_out),  32'd0);
    check("overlap_bits_hold", 32'(bits_out),   32'h0000B498);
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    check("restart_busy",        32'(accept_out), 32'd0);
    check("restart_ovf_cleared", 32'(ovf_count),  32'd0);
    check("restart_bits_cleared", 32'(bits_out),  32'd0);
    wait_ready(1'b0, edges);
    check("restart_latency", 32'(edges),     32'd9);
    check("restart_bits",    32'(bits_out),  32'h0000FFFF);
    check("restart_ovf",     32'(ovf_count), 32'd0);
    do_accept("restart");

    // Reset while the slicer is on element 4
    start({8{16'h7FFF}});
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("mid_ovf_before_rst", 32'(ovf_count), 32'd4);
    reset = 1'b1;
    #1;
    check("mid_rst_accept_out", 32'(accept_out), 32'd1);
    check("mid_rst_ready_out",  32'(ready_out),  32'd0);
    check("mid_rst_bits",       32'(bits_out),   32'd0);
    check("mid_rst_ovf",        32'(ovf_count),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start(test_vec);
    wait_ready(1'b0, edges);
    check("post_rst_latency", 32'(edges),     32'd9);
    check("post_rst_bits",    32'(bits_out),  32'h0000B498);
    check("post_rst_ovf",     32'(ovf_count), 32'd2);
    do_accept("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
